// File: rtl/alu_writeback_serializer.sv
// Serializes up to three GPR write-backs per ALU result record onto one register-file write port.
// Optional performance counters (retired_cnt, stall_cnt) are enabled by defining ALU_WB_PERF_EN.
module alu_writeback_serializer #(
  parameter int N = 32,
  parameter int R = 32,
  parameter int O = $clog2(R)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] GPR_a_dat,
  input  logic [N-1:0] GPR_b_dat,
  input  logic [N-1:0] GPR_c_dat,
  input  logic         GPR_a_val,
  input  logic         GPR_b_val,
  input  logic         GPR_c_val,
  input  logic [O-1:0] GPR_a_idx,
  input  logic [O-1:0] GPR_b_idx,
  input  logic [O-1:0] GPR_c_idx,
  input  logic [N-1:0] SPR_h_dat,
  input  logic [N-1:0] SPR_l_dat,
  input  logic         SPR_h_val,
  input  logic         SPR_l_val,
  input  logic         SPR_o_val,
  input  logic         SPR_z_val,
  output logic         rf_we,
  output logic [O-1:0] rf_waddr,
  output logic [N-1:0] rf_wdata,
  input  logic         rf_gnt,
  output logic         hi_we,
  output logic         lo_we,
  output logic [N-1:0] hi_wdata,
  output logic [N-1:0] lo_wdata,
  output logic         ovf_flag,
  output logic         zero_flag
`ifdef ALU_WB_PERF_EN
  ,
  output logic [31:0]  retired_cnt,
  output logic [31:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WR_A, WR_B, WR_C} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic [2:0]     pend_in;
  logic [2:0]     pend_q;
  logic [O-1:0]   a_idx_q;
  logic [O-1:0]   b_idx_q;
  logic [O-1:0]   c_idx_q;
  logic [N-1:0]   a_dat_q;
  logic [N-1:0]   b_dat_q;
  logic [N-1:0]   c_dat_q;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  // Writes targeting $zero are dropped here so they never occupy a write cycle.
  assign pend_in = {GPR_c_val & (GPR_c_idx != '0),
                    GPR_b_val & (GPR_b_idx != '0),
                    GPR_a_val & (GPR_a_idx != '0)};

  function automatic state_t first_pending(input logic [2:0] mask);
    if (mask[0])      return WR_A;
    else if (mask[1]) return WR_B;
    else if (mask[2]) return WR_C;
    else              return IDLE;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Record slots are captured only in the accept cycle; they stay frozen while draining.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q  <= '0;
      a_idx_q <= '0;
      b_idx_q <= '0;
      c_idx_q <= '0;
      a_dat_q <= '0;
      b_dat_q <= '0;
      c_dat_q <= '0;
    end else if (accept) begin
      pend_q  <= pend_in;
      a_idx_q <= GPR_a_idx;
      b_idx_q <= GPR_b_idx;
      c_idx_q <= GPR_c_idx;
      a_dat_q <= GPR_a_dat;
      b_dat_q <= GPR_b_dat;
      c_dat_q <= GPR_c_dat;
    end
  end

  // HI/LO strobes pulse once after accept; data and flags hold until the next record.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_we     <= 1'b0;
      lo_we     <= 1'b0;
      hi_wdata  <= '0;
      lo_wdata  <= '0;
      ovf_flag  <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      hi_we <= accept & SPR_h_val;
      lo_we <= accept & SPR_l_val;
      if (accept & SPR_h_val) hi_wdata <= SPR_h_dat;
      if (accept & SPR_l_val) lo_wdata <= SPR_l_dat;
      if (accept) begin
        ovf_flag  <= SPR_o_val;
        zero_flag <= SPR_z_val;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = first_pending(pend_in);
      end
      WR_A: begin
        rf_we    = 1'b1;
        rf_waddr = a_idx_q;
        rf_wdata = a_dat_q;
        if (rf_gnt) state_nxt = first_pending({pend_q[2:1], 1'b0});
      end
      WR_B: begin
        rf_we    = 1'b1;
        rf_waddr = b_idx_q;
        rf_wdata = b_dat_q;
        if (rf_gnt) state_nxt = first_pending({pend_q[2], 2'b00});
      end
      WR_C: begin
        rf_we    = 1'b1;
        rf_waddr = c_idx_q;
        rf_wdata = c_dat_q;
        if (rf_gnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_WB_PERF_EN
  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (accept)           retired_cnt <= retired_cnt + 32'd1;
      if (rf_we && !rf_gnt) stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
